// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants for the seven-segment scan driver.
//   GLYPH_TABLE  : hex digit -> segment pattern, bit order {G,F,E,D,C,B,A}
//   hex_to_glyph : nibble lookup into GLYPH_TABLE
//   SEG_OFF      : segment bus value with every segment dark (before polarity)
//   DP_OFF       : decimal point dark (before polarity)
package seven_seg_pkg;

   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

   localparam logic [6:0] SEG_OFF = 7'h00;
   localparam logic       DP_OFF  = 1'b0;

   function automatic logic [6:0] hex_to_glyph(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seven_seg_mux_hex_glyph.sv
// hex_glyph
// Combinational hex-to-seven-segment decoder (active-high segments).
//   i_nibble : hex digit 0..F
//   o_seg    : segments {G,F,E,D,C,B,A}
module hex_glyph
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_glyph(i_nibble);

endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux
// Time-multiplexed driver for a bank of seven-segment digits sharing one
// segment bus. Each digit gets a CLK_DIV-cycle slot; the first DEAD cycles
// of a slot keep every anode off to suppress ghosting. New content is staged
// in a pending register and only copied to the display register at a frame
// boundary, so a frame is never torn.
//   clk        : sole clock
//   rst        : synchronous, active-high reset
//   en         : display enable (anodes only; counters keep running)
//   load       : capture value/dp into the pending register
//   value      : nibble i drives digit i, digit 0 rightmost
//   dp         : decimal point per digit
//   seg        : segments A..G on seg[0]..seg[6]
//   dp_out     : decimal point segment
//   an         : one-hot digit select
//   frame_tick : one-cycle pulse after each frame boundary
module seven_seg_mux
   import seven_seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter int DEAD           = 1,
   parameter int BLANK_LZ       = 1,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   output logic [6:0]            seg,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DIGITS);

   localparam logic [CW-1:0]     CNT_MAX  = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0]     IDX_MAX  = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic              DP_MASK  = (SEG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_idx;
   logic [4*DIGITS-1:0]  r_disp_val;
   logic [DIGITS-1:0]    r_disp_dp;
   logic [4*DIGITS-1:0]  r_pend_val;
   logic [DIGITS-1:0]    r_pend_dp;
   logic                 r_pend_flag;

   logic [6:0]           r_seg;
   logic                 r_dp;
   logic [DIGITS-1:0]    r_an;
   logic                 r_frame_tick;

   logic                 w_slot_end;
   logic                 w_frame_end;
   logic                 w_live;
   logic [DIGITS-1:0]    w_onehot;
   logic [DIGITS-1:0]    w_blank;
   logic                 w_zero_above;
   logic [3:0]           w_nibble;
   logic [6:0]           w_glyph;
   logic                 w_cur_dp;
   logic                 w_cur_blank;
   logic [DIGITS-1:0]    w_an_raw;

   assign w_slot_end  = (r_cnt == CNT_MAX);
   assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);

   // With no dead time the compare would be constant, so it is left out.
   generate
      if (DEAD == 0) begin : g_no_dead
         assign w_live = 1'b1;
      end else begin : g_dead
         localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
         assign w_live = (r_cnt >= DEAD_C);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A load coinciding with the boundary bypasses the pending stage, so the
   // newest content always wins and the flag ends up clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp_val  <= '0;
         r_disp_dp   <= '0;
         r_pend_val  <= '0;
         r_pend_dp   <= '0;
         r_pend_flag <= 1'b0;
      end else begin
         if (load) begin
            r_pend_val  <= value;
            r_pend_dp   <= dp;
            r_pend_flag <= 1'b1;
         end
         if (w_frame_end) begin
            if (load) begin
               r_disp_val  <= value;
               r_disp_dp   <= dp;
               r_pend_flag <= 1'b0;
            end else if (r_pend_flag) begin
               r_disp_val  <= r_pend_val;
               r_disp_dp   <= r_pend_dp;
               r_pend_flag <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_onehot = '0;
      w_nibble = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         w_onehot[i] = (r_idx == IW'(i));
         if (r_idx == IW'(i)) begin
            w_nibble = r_disp_val[i*4 +: 4];
         end
      end
   end

   // Walk from the most significant digit down; a digit is blanked while
   // every nibble from the top down to it is zero and its own dp is off.
   always_comb begin
      w_zero_above = 1'b1;
      w_blank      = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_above = w_zero_above && (r_disp_val[i*4 +: 4] == 4'h0);
         w_blank[i]   = (BLANK_LZ != 0) && w_zero_above && !r_disp_dp[i];
      end
   end

   hex_glyph u_hex_glyph (
      .i_nibble (w_nibble),
      .o_seg    (w_glyph)
   );

   assign w_cur_dp    = |(r_disp_dp & w_onehot);
   assign w_cur_blank = |(w_blank & w_onehot);
   assign w_an_raw    = (en && w_live && !w_cur_blank) ? w_onehot : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg        <= SEG_OFF ^ SEG_MASK;
         r_dp         <= DP_OFF ^ DP_MASK;
         r_an         <= AN_MASK;
         r_frame_tick <= 1'b0;
      end else begin
         r_seg        <= w_glyph ^ SEG_MASK;
         r_dp         <= w_cur_dp ^ DP_MASK;
         r_an         <= w_an_raw ^ AN_MASK;
         r_frame_tick <= w_frame_end;
      end
   end

   assign seg        = r_seg;
   assign dp_out     = r_dp;
   assign an         = r_an;
   assign frame_tick = r_frame_tick;

endmodule
